// File: rtl/sr_reg_dump_pkg.sv
// Shared types and widths for the sr_reg_dump debug register-dump engine.
package sr_reg_dump_pkg;

   localparam int REG_IDX_W = 5;
   localparam int DATA_W    = 32;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      SEND = 3'd2,
      SUM  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/sr_reg_dump_if.sv
// Output beat stream {index, data} with valid/ready handshake; master drives beats.
interface sr_reg_dump_if;
   import sr_reg_dump_pkg::*;

   logic                 out_valid;
   logic                 out_ready;
   logic [REG_IDX_W-1:0] out_index;
   logic [DATA_W-1:0]    out_data;
   logic                 out_last;
   logic                 out_sum;

   modport master (
      output out_valid, out_index, out_data, out_last, out_sum,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_index, out_data, out_last, out_sum,
      output out_ready
   );

endinterface

// File: rtl/sr_reg_dump.sv
// Debug register-dump engine: walks indices 0..NUM_REGS-1 on the CPU debug port and streams beats.
// Optional XOR checksum beat after the last register when SR_REG_DUMP_CHECKSUM_EN is defined.
module sr_reg_dump
   import sr_reg_dump_pkg::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [REG_IDX_W-1:0] regAddr,
   input  logic [DATA_W-1:0]    regData,
   sr_reg_dump_if.master        out_if
);

   localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

   state_t               state_q, state_d;
   logic [REG_IDX_W-1:0] idx_q, idx_d;
   logic [REG_IDX_W-1:0] index_q, index_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic                 valid;
   logic                 accept;
   logic                 is_last;

   assign valid   = (state_q == SEND) || (state_q == SUM);
   assign accept  = valid && out_if.out_ready;
   assign is_last = (idx_q == LAST_IDX);

`ifdef SR_REG_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
`endif

   // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      index_d = index_q;
      data_d  = data_q;
`ifdef SR_REG_DUMP_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         IDLE: if (start) state_d = READ;
         READ: begin
            data_d  = regData;
            index_d = idx_q;
`ifdef SR_REG_DUMP_CHECKSUM_EN
            sum_d   = sum_q ^ regData;
`endif
            state_d = SEND;
         end
         SEND: begin
            if (accept) begin
               if (is_last) begin
`ifdef SR_REG_DUMP_CHECKSUM_EN
                  state_d = SUM;
`else
                  state_d = DONE;
`endif
               end else begin
                  idx_d   = idx_q + REG_IDX_W'(1);
                  state_d = READ;
               end
            end
         end
`ifdef SR_REG_DUMP_CHECKSUM_EN
         SUM: if (accept) state_d = DONE;
`endif
         DONE: begin
            idx_d   = '0;
`ifdef SR_REG_DUMP_CHECKSUM_EN
            sum_d   = '0;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         index_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         index_q <= index_d;
         data_q  <= data_d;
      end
   end

`ifdef SR_REG_DUMP_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sum_q <= '0;
      else      sum_q <= sum_d;
   end
`endif

   // The read address tracks the walk counter, so it holds through backpressure and is 0 in IDLE.
   assign busy             = (state_q != IDLE);
   assign done             = (state_q == DONE);
   assign regAddr          = idx_q;
   assign out_if.out_valid = valid;

`ifdef SR_REG_DUMP_CHECKSUM_EN
   assign out_if.out_index = (state_q == SUM) ? '0 : index_q;
   assign out_if.out_data  = (state_q == SUM) ? sum_q : data_q;
   assign out_if.out_last  = (state_q == SUM);
   assign out_if.out_sum   = (state_q == SUM);
`else
   assign out_if.out_index = index_q;
   assign out_if.out_data  = data_q;
   assign out_if.out_last  = (state_q == SEND) && is_last;
   assign out_if.out_sum   = 1'b0;
`endif

endmodule

// File: tb/tb_sr_reg_dump.sv
// Self-checking bench for sr_reg_dump: a 4-register instance and a full 32-register instance.
module tb_sr_reg_dump;
  import sr_reg_dump_pkg::*;

`ifdef SR_REG_DUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct {
    int          stall;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
    logic        sum;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Small instance: regData model selectable between offset pattern and one-hot pattern.
  logic        start_a = 1'b0, busy_a, done_a;
  logic [4:0]  addr_a;
  logic [31:0] data_a;
  int          mode_a = 0;
  sr_reg_dump_if a_if ();
  always_comb data_a = (mode_a == 1) ? (32'd1 << addr_a) : (32'h1000_0000 + 32'(addr_a));

  sr_reg_dump #(.NUM_REGS(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .regAddr(addr_a), .regData(data_a), .out_if(a_if.master)
  );

  // Full instance: CPU model with PC at address 0 and a register file elsewhere.
  logic        start_b = 1'b0, busy_b, done_b;
  logic [4:0]  addr_b;
  logic [31:0] data_b;
  logic [31:0] pc;
  logic [31:0] regs [32];
  sr_reg_dump_if b_if ();
  always_comb data_b = (addr_b == 5'd0) ? pc : regs[addr_b];

  sr_reg_dump #(.NUM_REGS(32)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .regAddr(addr_b), .regData(data_b), .out_if(b_if.master)
  );

  int beats_a = 0, dones_a = 0, beats_b = 0, dones_b = 0;
  always @(posedge clk) begin
    if (a_if.out_valid && a_if.out_ready) beats_a <= beats_a + 1;
    if (b_if.out_valid && b_if.out_ready) beats_b <= beats_b + 1;
    if (done_a) dones_a <= dones_a + 1;
    if (done_b) dones_b <= dones_b + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Waits for a beat, holds it for 'stall' cycles checking it each cycle, then accepts it.
  task automatic beat_a(input int stall, input vec_t v, input bit poke, input string tag);
    int n = 0;
    while (!a_if.out_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, " valid"}, 64'(a_if.out_valid), 64'd1);
    for (int s = 0; s <= stall; s++) begin
      a_if.out_ready = (s == stall);
      if (poke) start_a = (s == 0);
      check({tag, " index"}, 64'(a_if.out_index), 64'(v.idx));
      check({tag, " data"},  64'(a_if.out_data),  64'(v.data));
      check({tag, " last"},  64'(a_if.out_last),  64'(v.last));
      check({tag, " sum"},   64'(a_if.out_sum),   64'(v.sum));
      @(negedge clk);
    end
    a_if.out_ready = 1'b0;
    start_a        = 1'b0;
  endtask

  task automatic beat_b(input int stall, input vec_t v, input string tag);
    int n = 0;
    while (!b_if.out_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, " valid"}, 64'(b_if.out_valid), 64'd1);
    for (int s = 0; s <= stall; s++) begin
      b_if.out_ready = (s == stall);
      check({tag, " index"}, 64'(b_if.out_index), 64'(v.idx));
      check({tag, " data"},  64'(b_if.out_data),  64'(v.data));
      check({tag, " last"},  64'(b_if.out_last),  64'(v.last));
      check({tag, " sum"},   64'(b_if.out_sum),   64'(v.sum));
      @(negedge clk);
    end
    b_if.out_ready = 1'b0;
  endtask

  task automatic wait_done_a(input int exp_cyc, input string tag);
    int n = 0;
    while (!done_a && n < 100) begin @(negedge clk); n++; end
    check({tag, " done seen"}, 64'(done_a), 64'd1);
    check({tag, " done cycle"}, 64'(cyc), 64'(exp_cyc));
  endtask

  // One dump on the 32-register instance with random backpressure and mid-dump register writes.
  // abort_at >= 0 pulls reset asynchronously while that index is being offered.
  task automatic run_dump_b(input int stall_max, input int abort_at, input string tag);
    int          t0, stalls, b0, d0, n;
    logic [31:0] acc;
    vec_t        v;
    stalls = 0; acc = '0;
    b0 = beats_b; d0 = dones_b;
    t0 = cyc;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == abort_at) begin
        n = 0;
        while (!b_if.out_valid && n < 50) begin @(negedge clk); n++; end
        check({tag, " abort index"}, 64'(b_if.out_index), 64'(i));
        #2 rst = 1'b0;
        #1;
        check({tag, " rst busy"},  64'(busy_b),          64'd0);
        check({tag, " rst done"},  64'(done_b),          64'd0);
        check({tag, " rst addr"},  64'(addr_b),          64'd0);
        check({tag, " rst valid"}, 64'(b_if.out_valid),  64'd0);
        check({tag, " rst index"}, 64'(b_if.out_index),  64'd0);
        check({tag, " rst data"},  64'(b_if.out_data),   64'd0);
        check({tag, " rst last"},  64'(b_if.out_last),   64'd0);
        check({tag, " rst sum"},   64'(b_if.out_sum),    64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, " no done after abort"}, 64'(dones_b - d0), 64'd0);
        check({tag, " idle after abort"}, 64'(busy_b), 64'd0);
        return;
      end
      v.stall = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
      v.idx   = 5'(i);
      v.data  = (i == 0) ? pc : regs[i];
      v.last  = (i == 31) && !CK;
      v.sum   = 1'b0;
      acc     = acc ^ v.data;
      stalls += v.stall;
      beat_b(v.stall, v, tag);
      if (i + 2 < 32 && ($urandom % 4) == 0) regs[i + 2] = $urandom;
    end
`ifdef SR_REG_DUMP_CHECKSUM_EN
    v = '{stall: 0, idx: 5'd0, data: acc, last: 1'b1, sum: 1'b1};
    beat_b(0, v, {tag, " checksum"});
`endif
    n = 0;
    while (!done_b && n < 100) begin @(negedge clk); n++; end
    check({tag, " done seen"}, 64'(done_b), 64'd1);
    check({tag, " done cycle"}, 64'(cyc), 64'(t0 + 65 + int'(CK) + stalls));
    repeat (3) @(negedge clk);
    check({tag, " beat count"}, 64'(beats_b - b0), 64'(32 + int'(CK)));
    check({tag, " done count"}, 64'(dones_b - d0), 64'd1);
    check({tag, " idle after"}, 64'(busy_b), 64'd0);
  endtask

  vec_t tbl [5];
  int   nb;

  initial begin
    int t0, b0, d0;
    vec_t v;
    a_if.out_ready = 1'b0;
    b_if.out_ready = 1'b0;
    pc = 32'h8000_0100;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 + 32'(i);

    for (int i = 0; i < 4; i++)
      tbl[i] = '{stall: (i == 1) ? 5 : 0, idx: 5'(i), data: 32'h1000_0000 + 32'(i),
                 last: (i == 3) && !CK, sum: 1'b0};
    tbl[4] = '{stall: 0, idx: 5'd0, data: 32'h0, last: 1'b1, sum: 1'b1};
    nb = CK ? 5 : 4;

    repeat (2) @(negedge clk);
    check("reset busy",  64'(busy_a),          64'd0);
    check("reset done",  64'(done_a),          64'd0);
    check("reset addr",  64'(addr_a),          64'd0);
    check("reset valid", 64'(a_if.out_valid),  64'd0);
    check("reset index", 64'(a_if.out_index),  64'd0);
    check("reset data",  64'(a_if.out_data),   64'd0);
    check("reset last",  64'(a_if.out_last),   64'd0);
    check("reset sum",   64'(a_if.out_sum),    64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Pass 0: index ordering at full rate; pass 1: 5-cycle stall on index 1; pass 2: ignored start.
    for (int p = 0; p < 3; p++) begin
      b0 = beats_a; d0 = dones_a;
      t0 = cyc;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check($sformatf("p%0d busy", p), 64'(busy_a), 64'd1);
      check($sformatf("p%0d addr0", p), 64'(addr_a), 64'd0);
      for (int i = 0; i < nb; i++) begin
        int st;
        st = (p == 1) ? tbl[i].stall : ((p == 2 && i == 2) ? 1 : 0);
        beat_a(st, tbl[i], (p == 2 && i == 2), $sformatf("p%0d beat%0d", p, i));
      end
      wait_done_a(t0 + 9 + int'(CK) + ((p == 1) ? 5 : 0) + ((p == 2) ? 1 : 0), $sformatf("p%0d", p));
      repeat (4) @(negedge clk);
      check($sformatf("p%0d beats", p), 64'(beats_a - b0), 64'(nb));
      check($sformatf("p%0d dones", p), 64'(dones_a - d0), 64'd1);
      check($sformatf("p%0d idle", p),  64'(busy_a), 64'd0);
      check($sformatf("p%0d addr idle", p), 64'(addr_a), 64'd0);
    end

`ifdef SR_REG_DUMP_CHECKSUM_EN
    mode_a = 1;
    t0 = cyc;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = '{stall: 0, idx: 5'(i), data: 32'd1 << i, last: 1'b0, sum: 1'b0};
      beat_a(0, v, 1'b0, $sformatf("ck beat%0d", i));
    end
    v = '{stall: 0, idx: 5'd0, data: 32'hF, last: 1'b1, sum: 1'b1};
    beat_a(0, v, 1'b0, "ck sum beat");
    wait_done_a(t0 + 10, "ck");
    mode_a = 0;
`endif

    // Full-width dumps with random register contents and backpressure.
    for (int r = 0; r < 3; r++) begin
      pc = $urandom;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      run_dump_b((r == 0) ? 0 : 2, -1, $sformatf("full%0d", r));
    end

    // Asynchronous reset while index 10 is offered, then a clean dump from index 0.
    run_dump_b(1, 10, "abort");
    pc = $urandom;
    run_dump_b(1, -1, "after abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
